// File: rtl/snn_spike_encoder_if.sv
// Feature-vector handshake and spike-frame bus between a feature source and the SNN spike encoder.
// The encoder attaches as the slave; the feature producer / spike consumer attaches as the master.
interface snn_spike_encoder_if #(
    parameter int N_CH   = 16,
    parameter int FEAT_W = 8,
    parameter int STEP_W = 5
);
    logic [N_CH*FEAT_W-1:0] feat_data;
    logic                   feat_valid;
    logic                   feat_ready;
    logic                   abort;
    logic [N_CH-1:0]        input_spikes;
    logic                   spike_valid;
    logic                   spike_last;
    logic [STEP_W-1:0]      step_idx;
    logic                   busy;

    modport master (
        output feat_data, feat_valid, abort,
        input  feat_ready, input_spikes, spike_valid, spike_last, step_idx, busy
    );

    modport slave (
        input  feat_data, feat_valid, abort,
        output feat_ready, input_spikes, spike_valid, spike_last, step_idx, busy
    );
endinterface

// File: rtl/snn_spike_encoder.sv
// Rate-codes one latched feature vector into N_STEPS spike frames using per-channel
// sigma-delta accumulators; frames are spaced GAP cycles apart.
module snn_spike_encoder #(
    parameter int N_CH    = 16,
    parameter int FEAT_W  = 8,
    parameter int N_STEPS = 32,
    parameter int GAP     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    snn_spike_encoder_if.slave   enc
);
    localparam int STEP_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int GAP_LOAD = (GAP >= 2) ? GAP - 2 : 0;
    localparam int GAP_W    = (GAP_LOAD > 1) ? $clog2(GAP_LOAD + 1) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EMIT = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);
    localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(GAP_LOAD);

    logic [1:0]        state_reg;
    logic [STEP_W-1:0] step_reg;
    logic [GAP_W-1:0]  gap_reg;
    logic              feat_ready_reg;
    logic [N_CH-1:0]   input_spikes_reg;
    logic              spike_valid_reg;
    logic              spike_last_reg;
    logic [STEP_W-1:0] step_idx_reg;

    logic [N_CH-1:0]   fire;
    logic              accept;
    logic              emit_go;

    assign accept  = (state_reg == IDLE) && enc.feat_valid && feat_ready_reg && !enc.abort;
    assign emit_go = (state_reg == EMIT) && !enc.abort;

    // One accumulator per channel; the carry out of the FEAT_W-bit sum is the spike.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [FEAT_W-1:0] feat_reg;
            logic [FEAT_W-1:0] acc_reg;
            logic [FEAT_W:0]   sum;

            assign sum      = {1'b0, acc_reg} + {1'b0, feat_reg};
            assign fire[gi] = sum[FEAT_W];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    feat_reg <= '0;
                    acc_reg  <= '0;
                end else if (accept) begin
                    feat_reg <= enc.feat_data[gi*FEAT_W +: FEAT_W];
                    acc_reg  <= '0;
                end else if (emit_go) begin
                    acc_reg  <= sum[FEAT_W-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            step_reg         <= '0;
            gap_reg          <= '0;
            feat_ready_reg   <= 1'b0;
            input_spikes_reg <= '0;
            spike_valid_reg  <= 1'b0;
            spike_last_reg   <= 1'b0;
            step_idx_reg     <= '0;
        end else begin
            spike_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        feat_ready_reg <= 1'b0;
                        step_reg       <= '0;
                        state_reg      <= EMIT;
                    end else begin
                        feat_ready_reg <= 1'b1;
                    end
                end
                EMIT: begin
                    if (enc.abort) begin
                        state_reg      <= IDLE;
                        spike_last_reg <= 1'b0;
                        feat_ready_reg <= 1'b1;
                    end else begin
                        input_spikes_reg <= fire;
                        spike_valid_reg  <= 1'b1;
                        step_idx_reg     <= step_reg;
                        spike_last_reg   <= (step_reg == LAST_STEP);
                        if (step_reg == LAST_STEP) begin
                            state_reg      <= IDLE;
                            feat_ready_reg <= 1'b1;
                        end else begin
                            step_reg <= step_reg + 1'b1;
                            if (GAP == 1) begin
                                state_reg <= EMIT;
                            end else begin
                                state_reg <= WAIT;
                                gap_reg   <= GAP_INIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (enc.abort) begin
                        state_reg      <= IDLE;
                        spike_last_reg <= 1'b0;
                        feat_ready_reg <= 1'b1;
                    end else if (gap_reg == '0) begin
                        state_reg <= EMIT;
                    end else begin
                        gap_reg <= gap_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign enc.feat_ready   = feat_ready_reg;
    assign enc.input_spikes = input_spikes_reg;
    assign enc.spike_valid  = spike_valid_reg;
    assign enc.spike_last   = spike_last_reg;
    assign enc.step_idx     = step_idx_reg;
    assign enc.busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_snn_spike_encoder.sv
// Directed bench for snn_spike_encoder: one instance at N_STEPS=32/GAP=4, one at N_STEPS=4/GAP=1.
`timescale 1ns/1ps
module tb_snn_spike_encoder;
    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int          acc_cyc;
    int          last_cyc;
    int          total;
    int          c1;
    int          c2;
    int          n_sv;
    logic [127:0] mix;
    logic [15:0]  exp_f;

    snn_spike_encoder_if #(.N_CH(16), .FEAT_W(8), .STEP_W(5)) ifa ();
    snn_spike_encoder_if #(.N_CH(16), .FEAT_W(8), .STEP_W(2)) ifb ();

    snn_spike_encoder #(.N_CH(16), .FEAT_W(8), .N_STEPS(32), .GAP(4)) u_a (
        .clk   (clk),
        .reset (reset),
        .enc   (ifa.slave)
    );

    snn_spike_encoder #(.N_CH(16), .FEAT_W(8), .N_STEPS(4), .GAP(1)) u_b (
        .clk   (clk),
        .reset (reset),
        .enc   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next spike_valid on instance A, bounded to 20 cycles.
    task automatic wait_sv_a(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (ifa.spike_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, {31'b0, ifa.spike_valid}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        ifa.feat_valid = 1'b0; ifa.feat_data = '0; ifa.abort = 1'b0;
        ifb.feat_valid = 1'b0; ifb.feat_data = '0; ifb.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  ifa.feat_ready,   0);
        chk("rst_spikes", ifa.input_spikes, 0);
        chk("rst_valid",  ifa.spike_valid,  0);
        chk("rst_last",   ifa.spike_last,   0);
        chk("rst_step",   ifa.step_idx,     0);
        chk("rst_busy",   ifa.busy,         0);

        // All channels at 128: alternate 0/1 firing, 16 spikes per channel.
        reset = 1'b0;
        ifa.feat_valid = 1'b1;
        ifa.feat_data  = {16{8'h80}};
        @(negedge clk);
        chk("ready_rise", ifa.feat_ready, 1);
        acc_cyc = cyc + 1;
        @(negedge clk);
        ifa.feat_valid = 1'b0;
        chk("t1_busy",  ifa.busy, 1);
        chk("t1_ready", ifa.feat_ready, 0);
        total = 0;
        for (int k = 0; k < 32; k++) begin
            wait_sv_a("t1");
            chk("t1_cyc",  cyc, acc_cyc + 1 + 4*k);
            chk("t1_step", ifa.step_idx, k);
            chk("t1_last", ifa.spike_last, (k == 31) ? 1 : 0);
            if (k < 2) chk("t1_frame", ifa.input_spikes, (k == 0) ? 32'h0 : 32'hFFFF);
            total += $countones(ifa.input_spikes);
        end
        chk("t1_total", total, 256);
        @(negedge clk);
        chk("t1_ready_after", ifa.feat_ready, 1);
        chk("t1_ready_cyc", cyc, acc_cyc + 126);
        chk("t1_idle", ifa.busy, 0);

        // Mixed features, with feat_valid/feat_data toggled while busy.
        mix = '0;
        mix[15:8]  = 8'd64;
        mix[23:16] = 8'd255;
        mix[31:24] = 8'd1;
        ifa.feat_data  = mix;
        ifa.feat_valid = 1'b1;
        @(negedge clk);
        c1 = 0; c2 = 0; total = 0;
        for (int k = 0; k < 32; k++) begin
            if (k == 0) ifa.feat_valid = 1'b0;
            wait_sv_a("t2");
            exp_f    = 16'h0;
            exp_f[2] = (k != 0);
            exp_f[1] = (k % 4 == 3);
            chk("t2_frame", ifa.input_spikes, exp_f);
            c1 += ifa.input_spikes[1] ? 1 : 0;
            c2 += ifa.input_spikes[2] ? 1 : 0;
            total += $countones(ifa.input_spikes);
            if (k < 31) begin
                ifa.feat_valid = k[0];
                ifa.feat_data  = {16{8'hFF}};
            end else begin
                ifa.feat_valid = 1'b0;
            end
        end
        chk("t2_cnt_ch1", c1, 8);
        chk("t2_cnt_ch2", c2, 31);
        chk("t2_cnt_all", total, 39);

        // Back-to-back with feat_valid held: second accept on the spike_last cycle's edge.
        @(negedge clk);
        ifa.feat_valid = 1'b1;
        ifa.feat_data  = {16{8'h40}};
        acc_cyc = cyc + 1;
        last_cyc = 0;
        for (int k = 0; k < 32; k++) begin
            wait_sv_a("t3");
            chk("t3_cyc", cyc, acc_cyc + 1 + 4*k);
            chk("t3_frame", ifa.input_spikes, (k % 4 == 3) ? 32'hFFFF : 32'h0);
            if (k == 31) begin
                last_cyc = cyc;
                ifa.feat_data = {16{8'hFF}};
            end
        end
        wait_sv_a("t3b0");
        chk("t3b_cyc0",   cyc, last_cyc + 2);
        chk("t3b_step0",  ifa.step_idx, 0);
        chk("t3b_frame0", ifa.input_spikes, 32'h0);
        wait_sv_a("t3b1");
        ifa.feat_valid = 1'b0;
        chk("t3b_cyc1",   cyc, last_cyc + 6);
        chk("t3b_frame1", ifa.input_spikes, 32'hFFFF);

        // Abort during the third frame's WAIT cycle.
        wait_sv_a("t4");
        chk("t4_step2", ifa.step_idx, 2);
        ifa.abort = 1'b1;
        @(negedge clk);
        ifa.abort = 1'b0;
        chk("t4_ready", ifa.feat_ready, 1);
        chk("t4_busy",  ifa.busy, 0);
        chk("t4_valid", ifa.spike_valid, 0);
        n_sv = 0;
        repeat (12) begin
            @(negedge clk);
            if (ifa.spike_valid) n_sv++;
        end
        chk("t4_no_frames", n_sv, 0);
        ifa.feat_valid = 1'b1;
        ifa.feat_data  = {16{8'h80}};
        @(negedge clk);
        ifa.feat_valid = 1'b0;
        wait_sv_a("t4r0");
        chk("t4r_step0",  ifa.step_idx, 0);
        chk("t4r_frame0", ifa.input_spikes, 32'h0);
        wait_sv_a("t4r1");
        chk("t4r_step1",  ifa.step_idx, 1);
        chk("t4r_frame1", ifa.input_spikes, 32'hFFFF);

        // Asynchronous reset in the middle of WAIT.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_spikes", ifa.input_spikes, 0);
        chk("ar_valid",  ifa.spike_valid, 0);
        chk("ar_step",   ifa.step_idx, 0);
        chk("ar_last",   ifa.spike_last, 0);
        chk("ar_busy",   ifa.busy, 0);
        chk("ar_ready",  ifa.feat_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        n_sv = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifa.spike_valid) n_sv++;
        end
        chk("ar_no_frames", n_sv, 0);
        chk("ar_ready_back", ifa.feat_ready, 1);

        // GAP=1, N_STEPS=4 instance: four consecutive frames.
        chk("b_ready", ifb.feat_ready, 1);
        ifb.feat_valid = 1'b1;
        ifb.feat_data  = {16{8'hFF}};
        @(negedge clk);
        ifb.feat_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b_valid", ifb.spike_valid, 1);
            chk("b_step",  ifb.step_idx, k);
            chk("b_frame", ifb.input_spikes, (k == 0) ? 32'h0 : 32'hFFFF);
            chk("b_last",  ifb.spike_last, (k == 3) ? 1 : 0);
        end
        @(negedge clk);
        chk("b_valid_end", ifb.spike_valid, 0);
        chk("b_ready_end", ifb.feat_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
